div_seq: RTL and testbench
==========================

// Module: div_seq
// PURPOSE
//  Multi-cycle sequencer for the MIPS DIV/DIVU instructions. Reuses one 32-bit shift-subtract step per cycle
//  (restoring division) instead of a combinational divider. Sits beside the ALU in EX; drives HI (remainder)
//  and LO (quotient) write data. Stalls the pipeline via busy.
// PARAMETERS
//  WIDTH      32   operand/result width (only 32 is verified)
//  CNT_W      5    step counter width, log2(WIDTH)
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      synchronous, active-high
//  start      in   1      request; sampled only in IDLE
//  sign       in   1      1 = DIV (signed), 0 = DIVU
//  dividend   in   32     A operand (rs)
//  divisor    in   32     B operand (rt)
//  busy       out  1      high in RUN and FIX
//  done       out  1      one-cycle pulse, result valid
//  quotient   out  32     LO write data
//  remainder  out  32     HI write data
//  div_zero   out  1      divisor was 0; valid with done, held until next start
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, div_zero=0, quotient=0, remainder=0, counter=0. Reset in any state,
//   including mid-RUN, aborts the operation: no done pulse, outputs cleared at the same edge.
//  States: IDLE -> RUN -> FIX -> DONE -> IDLE; IDLE -> DONE directly on divide-by-zero.
//  IDLE: start=1 latches operands and sign. divisor!=0 -> RUN, counter=0. divisor==0 -> DONE.
//   Latched magnitudes: |dividend|, |divisor| when sign=1, else raw values. Signs of dividend/divisor are stored.
//  RUN: one step per cycle: {rem,quo} shifted left 1; trial = rem - |divisor| (33-bit, unsigned);
//   trial non-negative -> rem=trial, quo[0]=1, else rem kept, quo[0]=0. Exactly 32 RUN cycles; counter
//   wraps 31->0 on the exit edge into FIX.
//  FIX (1 cycle): signed only: quotient negated if operand signs differ; remainder negated if dividend < 0.
//  DONE (1 cycle): done=1; quotient/remainder/div_zero registered and stable; next edge -> IDLE.
//  Latency: start sampled in cycle 0 -> RUN cycles 1..32, FIX cycle 33, done=1 in cycle 34. Div-by-zero: done=1 in cycle 1.
//  Divide-by-zero result: quotient=32'hFFFF_FFFF, remainder=dividend (raw), div_zero=1.
//  Signed overflow 0x8000_0000 / -1: no special case; result quotient=0x8000_0000, remainder=0, div_zero=0.
//  |0x8000_0000| is handled as unsigned 0x8000_0000 (no 32-bit saturation).
//  start while busy or in DONE: ignored, no queueing. start in the IDLE cycle following DONE is accepted.
//  quotient/remainder/div_zero hold their last value from DONE until the next accepted start; they update
//   only on the FIX->DONE or IDLE->DONE edge.
//  busy is registered (state decode); done is never high at the same time as busy.
// STRUCTURE
//  Package div_pkg: state localparams (IDLE, RUN, FIX, DONE), WIDTH, DIV0_QUOT = 32'hFFFF_FFFF.
//  Sub-module div_step: combinational one-bit shift/trial-subtract {rem_in,quo_in,dvsr} -> {rem_out,quo_out}.
//  div_seq contains the FSM, counter, operand/magnitude registers and sign fix-up.
// TESTING
//  DIVU 100 / 7 -> cycle 34 done=1, quotient=14, remainder=2, div_zero=0; busy high in cycles 1..33.
//  DIV -7 / 2 -> quotient=32'hFFFF_FFFD (-3), remainder=32'hFFFF_FFFF (-1); DIV 7 / -2 -> q=-3, r=1.
//  DIV 0x8000_0000 / 0xFFFF_FFFF -> quotient=0x8000_0000, remainder=0; DIVU same operands -> q=0, r=0x8000_0000.
//  divisor=0, dividend=0x1234 -> done in cycle 1, div_zero=1, q=FFFF_FFFF, r=0x1234; busy never high.
//  Pulse start with new operands in cycle 5 of a run -> ignored; result reflects the original operands.
//  reset in cycle 10 of a run -> next cycle IDLE, all outputs 0, no done pulse; new start then completes normally.

Source files
------------

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared width, sequencer states and divide-by-zero constant
//               for the DIV/DIVU sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int WIDTH = 32;

    localparam logic [WIDTH-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One restoring-division step: shift {rem,quo} left by one and
//               keep the trial subtraction when it does not borrow.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_dvsr,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0]   w_shifted;
    logic [WIDTH+1:0] w_trial;
    logic             w_borrow;

    // Extra top bit of the difference is the borrow of the unsigned trial.
    assign w_shifted = {i_rem, i_quo[WIDTH-1]};
    assign w_trial   = {1'b0, w_shifted} - {2'b00, i_dvsr};
    assign w_borrow  = w_trial[WIDTH+1];

    assign o_rem = w_borrow ? w_shifted[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign o_quo = {i_quo[WIDTH-2:0], ~w_borrow};

endmodule
`default_nettype wire

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
// Module      : div_seq
// Description : Multi-cycle MIPS DIV/DIVU sequencer (one restoring step per
//               cycle) producing LO (quotient) and HI (remainder).
// Revision    : 1.0 - initial release
// ============================================================================
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = div_pkg::WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvsr;
    logic               r_dvd_neg;
    logic               r_dvs_neg;

    logic [WIDTH-1:0]   w_dvd_mag;
    logic [WIDTH-1:0]   w_dvs_mag;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // The most negative value negates to itself and is then read as unsigned.
    assign w_dvd_mag = (sign && dividend[WIDTH-1]) ? -dividend : dividend;
    assign w_dvs_mag = (sign && divisor[WIDTH-1])  ? -divisor  : divisor;

    assign w_quo_fix = (r_dvd_neg ^ r_dvs_neg) ? -r_quo : r_quo;
    assign w_rem_fix = r_dvd_neg ? -r_rem : r_rem;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem  (r_rem),
        .i_quo  (r_quo),
        .i_dvsr (r_dvsr),
        .o_rem  (w_rem_next),
        .o_quo  (w_quo_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvsr    <= '0;
            r_dvd_neg <= 1'b0;
            r_dvs_neg <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_rem     <= '0;
                        r_quo     <= w_dvd_mag;
                        r_dvsr    <= w_dvs_mag;
                        r_dvd_neg <= sign & dividend[WIDTH-1];
                        r_dvs_neg <= sign & divisor[WIDTH-1];
                        r_cnt     <= '0;
                        if (divisor == '0) begin
                            r_state   <= DONE;
                            done      <= 1'b1;
                            quotient  <= DIV0_QUOT;
                            remainder <= dividend;
                            div_zero  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            busy    <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_state   <= DONE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    quotient  <= w_quo_fix;
                    remainder <= w_rem_fix;
                    div_zero  <= 1'b0;
                end
                DONE: begin
                    r_state <= IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_seq
// Description : Directed vector bench for the DIV/DIVU sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_seq;

    typedef struct packed {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic [7:0]  lat;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        sign;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;

    int checks   = 0;
    int failures = 0;

    vec_t vecs [11];

    div_seq #(
        .WIDTH (32),
        .CNT_W (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sign      (sign),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive one operation from the current negedge; inject >0 pulses start
    // with other operands after that many edges (expected to be ignored).
    task automatic run_div(input vec_t v, input int inject, input string tag);
        int          lat;
        int          busy_bad;
        logic [31:0] held_q;
        start    = 1'b1;
        sign     = v.sgn;
        dividend = v.a;
        divisor  = v.b;
        lat      = -1;
        busy_bad = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == inject) begin
                start    = 1'b1;
                sign     = 1'b0;
                dividend = 32'd50;
                divisor  = 32'd5;
            end else begin
                start = 1'b0;
            end
            if (busy !== ((v.lat == 8'd34) && (n <= 33))) busy_bad++;
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'(v.lat));
        check({tag, "_q"}, quotient, v.q);
        check({tag, "_r"}, remainder, v.r);
        check({tag, "_dz"}, 32'(div_zero), 32'(v.dz));
        check({tag, "_busy"}, 32'(busy_bad), 32'd0);
        held_q = quotient;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
        check({tag, "_hold"}, quotient, v.q);
        if (held_q !== v.q) $display("note %s quotient at done=%h", tag, held_q);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 8'd34};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 8'd34};
        vecs[2]  = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0, 8'd34};
        vecs[3]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0, 8'd34};
        vecs[4]  = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 8'd34};
        vecs[5]  = '{1'b0, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 8'd1};
        vecs[6]  = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE, 1'b0, 8'd34};
        vecs[7]  = '{1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0, 8'd34};
        vecs[8]  = '{1'b0, 32'd5,         32'd10,        32'd0,         32'd5,         1'b0, 8'd34};
        vecs[9]  = '{1'b1, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b1, 8'd1};
        vecs[10] = '{1'b0, 32'hDEAD_BEEF, 32'h10,        32'h0DEA_DBEE, 32'hF,         1'b0, 8'd34};

        reset    = 1'b1;
        start    = 1'b0;
        sign     = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q", quotient, 32'd0);
        check("rst_r", remainder, 32'd0);
        check("rst_dz", 32'(div_zero), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Back-to-back: each run starts in the IDLE cycle right after DONE.
        for (int i = 0; i < 11; i++) begin
            run_div(vecs[i], 0, $sformatf("v%0d", i));
        end

        // Start pulsed mid-run with other operands must not disturb the result.
        run_div(vecs[0], 5, "ign_run");
        // Start held through the DONE cycle must not launch a new operation.
        run_div(vecs[7], 34, "ign_done");

        // Reset in cycle 10 of a run aborts it and clears the outputs.
        begin
            int stray;
            stray    = 0;
            start    = 1'b1;
            sign     = 1'b0;
            dividend = 32'd1000;
            divisor  = 32'd3;
            for (int n = 1; n <= 10; n++) begin
                @(posedge clk);
                @(negedge clk);
                start = 1'b0;
            end
            check("abort_busy_pre", 32'(busy), 32'd1);
            reset = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_done", 32'(done), 32'd0);
            check("abort_q", quotient, 32'd0);
            check("abort_r", remainder, 32'd0);
            check("abort_dz", 32'(div_zero), 32'd0);
            reset = 1'b0;
            for (int n = 0; n < 40; n++) begin
                @(negedge clk);
                if (done !== 1'b0 || busy !== 1'b0) stray++;
            end
            check("abort_no_done", 32'(stray), 32'd0);
        end
        run_div(vecs[6], 0, "post_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
